// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - MM:SS stopwatch mode controller and BCD time counter
// Optional button debounce is enabled by defining STOPWATCH_DEBOUNCE_EN.

module stopwatch_btn #(
    parameter int DEB_SAMPLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_fast,
    input  logic din,
    output logic press
);

    logic level;
    logic level_d;

`ifdef STOPWATCH_DEBOUNCE_EN
    logic [3:0] cnt;

    // Level flips only after DEB_SAMPLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= 4'd0;
        end else if (tick_fast) begin
            if (din != level) begin
                if (cnt == 4'(DEB_SAMPLES - 1)) begin
                    level <= din;
                    cnt   <= 4'd0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end else begin
                cnt <= 4'd0;
            end
        end
    end
`else
    logic unused_deb;

    assign level      = din;
    assign unused_deb = tick_fast ^ (DEB_SAMPLES == 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign press = level & ~level_d;

endmodule

module stopwatch_ctrl #(
    parameter int DEB_SAMPLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_fast,
    input  logic       tick_blink,
    input  logic       btn_pause,
    input  logic       btn_rst,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       blank_min,
    output logic       blank_sec,
    output logic       running
);

    typedef enum logic [1:0] {
        ST_PAUSE  = 2'd0,
        ST_RUN    = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       phase;
    logic       phase_nx;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic       pause_press;
    logic       rst_press;
    logic       adj_s;
    logic       sel_s;
    logic [8:0] sec_step;
    logic [7:0] min_step;
    logic [3:0] min_tens_nx;
    logic [3:0] min_ones_nx;
    logic [3:0] sec_tens_nx;
    logic [3:0] sec_ones_nx;

    // Returns {carry, tens, ones}; out-of-range digits recover to a legal value.
    function automatic logic [8:0] inc59(input logic [3:0] tens, input logic [3:0] ones);
        if (ones >= 4'd9) begin
            if (tens >= 4'd5) begin
                return {1'b1, 4'd0, 4'd0};
            end
            return {1'b0, tens + 4'd1, 4'd0};
        end
        return {1'b0, tens, ones + 4'd1};
    endfunction

    // Bit order: 0 btn_pause, 1 btn_rst, 2 sw_adj, 3 sw_sel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 4'd0;
            sync2 <= 4'd0;
        end else begin
            sync1 <= {sw_sel, sw_adj, btn_rst, btn_pause};
            sync2 <= sync1;
        end
    end

    assign adj_s = sync2[2];
    assign sel_s = sync2[3];

    stopwatch_btn #(.DEB_SAMPLES(DEB_SAMPLES)) u_btn_pause (
        .clk       (clk),
        .rst       (rst),
        .tick_fast (tick_fast),
        .din       (sync2[0]),
        .press     (pause_press)
    );

    stopwatch_btn #(.DEB_SAMPLES(DEB_SAMPLES)) u_btn_rst (
        .clk       (clk),
        .rst       (rst),
        .tick_fast (tick_fast),
        .din       (sync2[1]),
        .press     (rst_press)
    );

    assign sec_step = inc59(sec_tens, sec_ones);
    assign min_step = 8'(inc59(min_tens, min_ones));

    always_comb begin
        state_nx = state;
        case (state)
            ST_PAUSE: begin
                if (adj_s) begin
                    state_nx = ST_ADJUST;
                end else if (pause_press) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (adj_s) begin
                    state_nx = ST_ADJUST;
                end else if (pause_press) begin
                    state_nx = ST_PAUSE;
                end
            end
            ST_ADJUST: begin
                if (!adj_s) begin
                    state_nx = ST_PAUSE;
                end
            end
            default: state_nx = ST_PAUSE;
        endcase
    end

    always_comb begin
        phase_nx = phase;
        if (state != ST_ADJUST && state_nx == ST_ADJUST) begin
            phase_nx = 1'b0;
        end else if (state == ST_ADJUST && tick_blink) begin
            phase_nx = ~phase;
        end
    end

    // Ticks are judged against the current state, so a mode change in the same cycle still counts them.
    always_comb begin
        min_tens_nx = min_tens;
        min_ones_nx = min_ones;
        sec_tens_nx = sec_tens;
        sec_ones_nx = sec_ones;
        if (rst_press) begin
            min_tens_nx = 4'd0;
            min_ones_nx = 4'd0;
            sec_tens_nx = 4'd0;
            sec_ones_nx = 4'd0;
        end else if (state == ST_RUN && tick_1hz) begin
            {sec_tens_nx, sec_ones_nx} = sec_step[7:0];
            if (sec_step[8]) begin
                {min_tens_nx, min_ones_nx} = min_step;
            end
        end else if (state == ST_ADJUST && tick_2hz) begin
            if (sel_s) begin
                {sec_tens_nx, sec_ones_nx} = sec_step[7:0];
            end else begin
                {min_tens_nx, min_ones_nx} = min_step;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_PAUSE;
            phase     <= 1'b0;
            min_tens  <= 4'd0;
            min_ones  <= 4'd0;
            sec_tens  <= 4'd0;
            sec_ones  <= 4'd0;
            blank_min <= 1'b0;
            blank_sec <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_nx;
            phase     <= phase_nx;
            min_tens  <= min_tens_nx;
            min_ones  <= min_ones_nx;
            sec_tens  <= sec_tens_nx;
            sec_ones  <= sec_ones_nx;
            blank_min <= (state_nx == ST_ADJUST) && !sel_s && phase_nx;
            blank_sec <= (state_nx == ST_ADJUST) && sel_s && phase_nx;
            running   <= (state_nx == ST_RUN);
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl

module tb_stopwatch_ctrl;

    logic clk        = 1'b0;
    logic rst        = 1'b1;
    logic tick_1hz   = 1'b0;
    logic tick_2hz   = 1'b0;
    logic tick_fast  = 1'b1;
    logic tick_blink = 1'b0;
    logic btn_pause  = 1'b0;
    logic btn_rst    = 1'b0;
    logic sw_adj     = 1'b0;
    logic sw_sel     = 1'b0;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       blank_min;
    logic       blank_sec;
    logic       running;
    logic [15:0] disp;

    int vectors     = 0;
    int miscompares = 0;

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int PRESS_EDGES = 6;
`else
    localparam int PRESS_EDGES = 3;
`endif

    stopwatch_ctrl #(.DEB_SAMPLES(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .tick_2hz   (tick_2hz),
        .tick_fast  (tick_fast),
        .tick_blink (tick_blink),
        .btn_pause  (btn_pause),
        .btn_rst    (btn_rst),
        .sw_adj     (sw_adj),
        .sw_sel     (sw_sel),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .blank_min  (blank_min),
        .blank_sec  (blank_sec),
        .running    (running)
    );

    assign disp = {min_tens, min_ones, sec_tens, sec_ones};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_pause();
        btn_pause = 1'b1;
        repeat (PRESS_EDGES + 2) step();
        btn_pause = 1'b0;
        repeat (PRESS_EDGES + 2) step();
    endtask

    task automatic tick1(input int n);
        repeat (n) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            step();
        end
    endtask

    task automatic tick2(input int n);
        repeat (n) begin
            tick_2hz = 1'b1;
            step();
            tick_2hz = 1'b0;
            step();
        end
    endtask

    task automatic blink();
        tick_blink = 1'b1;
        step();
        tick_blink = 1'b0;
        step();
    endtask

    task automatic collide(input bit use_rst);
        if (use_rst) btn_rst = 1'b1;
        else btn_pause = 1'b1;
        repeat (PRESS_EDGES - 1) step();
        tick_1hz = 1'b1;
        step();
        tick_1hz  = 1'b0;
        btn_rst   = 1'b0;
        btn_pause = 1'b0;
        repeat (PRESS_EDGES + 2) step();
    endtask

    task automatic test_reset();
        vectors++; if (disp !== 16'h0000) begin miscompares++; $display("FAIL reset_digits: got %h want 0000", disp); end
        vectors++; if (blank_min !== 1'b0) begin miscompares++; $display("FAIL reset_blank_min: got %b want 0", blank_min); end
        vectors++; if (blank_sec !== 1'b0) begin miscompares++; $display("FAIL reset_blank_sec: got %b want 0", blank_sec); end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL reset_running: got %b want 0", running); end
        press_pause();
        tick1(5);
        vectors++; if (disp !== 16'h0005) begin miscompares++; $display("FAIL pre_async_count: got %h want 0005", disp); end
        #3 rst = 1'b1;
        #1;
        vectors++; if (disp !== 16'h0000) begin miscompares++; $display("FAIL async_digits: got %h want 0000", disp); end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL async_running: got %b want 0", running); end
        #2 rst = 1'b0;
        step();
    endtask

    task automatic test_count();
        press_pause();
        vectors++; if (running !== 1'b1) begin miscompares++; $display("FAIL count_running: got %b want 1", running); end
        tick1(61);
        vectors++; if (disp !== 16'h0101) begin miscompares++; $display("FAIL count_61: got %h want 0101", disp); end
    endtask

    task automatic test_adjust();
        sw_adj = 1'b1;
        sw_sel = 1'b1;
        repeat (4) step();
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL adj_running: got %b want 0", running); end
        vectors++; if ({blank_min, blank_sec} !== 2'b00) begin miscompares++; $display("FAIL adj_entry_blank: got %b want 00", {blank_min, blank_sec}); end
        tick2(57);
        vectors++; if (disp !== 16'h0158) begin miscompares++; $display("FAIL adj_58: got %h want 0158", disp); end
        tick2(3);
        vectors++; if (disp !== 16'h0101) begin miscompares++; $display("FAIL adj_wrap_sec: got %h want 0101", disp); end
        blink();
        vectors++; if ({blank_min, blank_sec} !== 2'b01) begin miscompares++; $display("FAIL adj_blink1: got %b want 01", {blank_min, blank_sec}); end
        blink();
        vectors++; if ({blank_min, blank_sec} !== 2'b00) begin miscompares++; $display("FAIL adj_blink2: got %b want 00", {blank_min, blank_sec}); end
    endtask

    task automatic test_wrap();
        tick2(58);
        sw_sel = 1'b0;
        repeat (4) step();
        tick2(58);
        vectors++; if (disp !== 16'h5959) begin miscompares++; $display("FAIL wrap_set: got %h want 5959", disp); end
        sw_adj = 1'b0;
        repeat (4) step();
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL wrap_pause: got %b want 0", running); end
        press_pause();
        vectors++; if (running !== 1'b1) begin miscompares++; $display("FAIL wrap_run: got %b want 1", running); end
        tick1(1);
        vectors++; if (disp !== 16'h0000) begin miscompares++; $display("FAIL wrap_0000: got %h want 0000", disp); end
        vectors++; if (running !== 1'b1) begin miscompares++; $display("FAIL wrap_still_run: got %b want 1", running); end
    endtask

    task automatic test_collisions();
        tick1(10);
        vectors++; if (disp !== 16'h0010) begin miscompares++; $display("FAIL col_setup1: got %h want 0010", disp); end
        collide(1'b1);
        vectors++; if (disp !== 16'h0000) begin miscompares++; $display("FAIL col_rst_tick: got %h want 0000", disp); end
        vectors++; if (running !== 1'b1) begin miscompares++; $display("FAIL col_rst_state: got %b want 1", running); end
        tick1(10);
        collide(1'b0);
        vectors++; if (disp !== 16'h0011) begin miscompares++; $display("FAIL col_pause_tick: got %h want 0011", disp); end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL col_pause_state: got %b want 0", running); end
    endtask

    task automatic test_mode_guard();
        sw_adj = 1'b1;
        repeat (4) step();
        press_pause();
        press_pause();
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL guard_running: got %b want 0", running); end
        tick1(1);
        vectors++; if (disp !== 16'h0011) begin miscompares++; $display("FAIL guard_no_count: got %h want 0011", disp); end
        blink();
        vectors++; if ({blank_min, blank_sec} !== 2'b10) begin miscompares++; $display("FAIL guard_blank_min: got %b want 10", {blank_min, blank_sec}); end
        sw_adj = 1'b0;
        repeat (4) step();
        vectors++; if ({running, blank_min, blank_sec} !== 3'b000) begin miscompares++; $display("FAIL guard_exit: got %b want 000", {running, blank_min, blank_sec}); end
        press_pause();
        vectors++; if (running !== 1'b1) begin miscompares++; $display("FAIL guard_back_pause: got %b want 1", running); end
    endtask

`ifdef STOPWATCH_DEBOUNCE_EN
    task automatic test_debounce();
        btn_pause = 1'b1; step();
        btn_pause = 1'b0; step();
        btn_pause = 1'b1; step();
        btn_pause = 1'b0;
        repeat (10) step();
        vectors++; if (running !== 1'b1) begin miscompares++; $display("FAIL deb_bounce: got %b want 1", running); end
        btn_pause = 1'b1;
        repeat (3) step();
        btn_pause = 1'b0;
        repeat (10) step();
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL deb_stable: got %b want 0", running); end
    endtask
`endif

    initial begin
        repeat (2) step();
        rst = 1'b0;
        step();
        test_reset();
        test_count();
        test_adjust();
        test_wrap();
        test_collisions();
        test_mode_guard();
`ifdef STOPWATCH_DEBOUNCE_EN
        test_debounce();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
